// File: rtl/adder_nbit_seq.sv
// Multi-cycle N-bit adder/subtractor.
// Adds CHUNK_BITS per clock, rippling a registered carry from the least
// significant chunk upward. A start/busy/done handshake frames each operation.
// Operands are latched on acceptance, so the inputs may change freely afterwards.
// NUM_BITS must be an exact multiple of CHUNK_BITS.
module adder_nbit_seq #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow,
    output logic                busy,
    output logic                done
);

    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state_q, state_d;

    // Operands and result are viewed as arrays of chunks.
    // This lets the active chunk be selected directly by the chunk index.
    logic [NUM_CHUNKS-1:0][CHUNK_BITS-1:0] a_q, b_q, sum_q;
    logic                                  carry_q;
    logic [IDX_W-1:0]                      idx_q;
    logic                                  accept;
    logic [CHUNK_BITS:0]                   chunk_res;

    assign sum = sum_q;

    // A new operation is taken only when no chunks are in flight.
    always_comb begin
        accept = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // One chunk of the ripple: the carry-out lands in the top bit.
    always_comb begin
        chunk_res = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + (CHUNK_BITS + 1)'(carry_q);
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? ADD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with <= so every flop in this edge sees the pre-edge values of the others.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture; subtraction is folded in as a + ~b + 1.
    always_ff @(posedge clk) begin
        // NOTE: operand holding registers are deliberately not reset.
        // They are always loaded before ADD reads them, so a reset would only add fan-out.
        if (accept) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
        end
    end

    // Chunk sequencing, carry chain and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            carry_q  <= sub | carry_in;
            idx_q    <= '0;
            sum_q    <= '0;
            overflow <= 1'b0;
        end else if (state_q == ADD) begin
            sum_q[idx_q] <= chunk_res[CHUNK_BITS-1:0];
            carry_q      <= chunk_res[CHUNK_BITS];
            idx_q        <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) overflow <= chunk_res[CHUNK_BITS];
        end
    end

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Testbench for adder_nbit_seq.
// It drives a 16/4 instance with directed and random operations.
// It also sweeps every input case of a 4/1 instance in add mode.
// The drivers push expected results into queues.
// The monitors pop those results and compare them whenever done is seen.
module tb_adder_nbit_seq;

    localparam int NB  = 16;
    localparam int CB  = 4;
    localparam int NC  = NB / CB;
    localparam int NB2 = 4;
    localparam int CB2 = 1;
    localparam int NC2 = NB2 / CB2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0, sub = 1'b0, carry_in = 1'b0;
    logic [NB-1:0] a = '0, b = '0, sum;
    logic          overflow, busy, done;

    logic           start2 = 1'b0, sub2 = 1'b0, carry_in2 = 1'b0;
    logic [NB2-1:0] a2 = '0, b2 = '0, sum2;
    logic           overflow2, busy2, done2;

    adder_nbit_seq #(.NUM_BITS(NB), .CHUNK_BITS(CB)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .sum(sum), .overflow(overflow), .busy(busy), .done(done)
    );

    adder_nbit_seq #(.NUM_BITS(NB2), .CHUNK_BITS(CB2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .carry_in(carry_in2), .sum(sum2), .overflow(overflow2), .busy(busy2), .done(done2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    // The reference model works on unsigned integers modulo 2^nbits.
    // In subtract mode, overflow means no borrow occurred, that is a >= b.
    function automatic exp_t model(input int nbits, input logic [31:0] x, input logic [31:0] y,
                                   input logic cin, input logic s, input int issue_cyc, input int nchunks);
        exp_t   e;
        longint m = longint'(1) << nbits;
        longint r;
        if (s) begin
            r     = longint'(x) - longint'(y);
            if (r < 0) r = r + m;
            e.sum = 32'(r);
            e.ov  = (x >= y);
        end else begin
            r     = longint'(x) + longint'(y) + longint'(cin);
            e.sum = 32'(r % m);
            e.ov  = (r >= m);
        end
        e.cyc = issue_cyc + 1 + nchunks;
        return e;
    endfunction

    // Monitor for the 16/4 instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && done) begin
            if (q1.size() == 0) fail_now("m1_unexpected_done", "done with no operation outstanding");
            else begin
                e = q1.pop_front();
                check("m1_sum", 32'(sum), e.sum);
                check("m1_overflow", 32'(overflow), 32'(e.ov));
                check("m1_latency", 32'(cyc), 32'(e.cyc));
                check("m1_busy_in_done", 32'(busy), 32'(0));
            end
        end
    end

    // Monitor for the 4/1 instance.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst && done2) begin
            if (q2.size() == 0) fail_now("m2_unexpected_done", "done with no operation outstanding");
            else begin
                e = q2.pop_front();
                check("m2_sum", 32'(sum2), e.sum);
                check("m2_overflow", 32'(overflow2), 32'(e.ov));
                check("m2_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge. After the call returns, the inputs are scrambled.
    // This shows that only the values latched at acceptance matter.
    task automatic issue1(input logic [NB-1:0] x, input logic [NB-1:0] y, input logic cin, input logic s);
        a = x; b = y; carry_in = cin; sub = s; start = 1'b1;
        q1.push_back(model(NB, 32'(x), 32'(y), cin, s, cyc, NC));
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done1(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) return;
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        fail_now("wait_done1", "timeout waiting for done");
    endtask

    task automatic issue2(input logic [NB2-1:0] x, input logic [NB2-1:0] y, input logic cin);
        a2 = x; b2 = y; carry_in2 = cin; sub2 = 1'b0; start2 = 1'b1;
        q2.push_back(model(NB2, 32'(x), 32'(y), cin, 1'b0, cyc, NC2));
        @(negedge clk);
        start2 = 1'b0;
        a2 = 4'($urandom); b2 = 4'($urandom); carry_in2 = 1'($urandom);
    endtask

    task automatic wait_done2;
        for (int i = 0; i < 20; i++) begin
            if (done2) return;
            @(negedge clk);
        end
        fail_now("wait_done2", "timeout waiting for done");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int bc;
        int gap;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));

        // Plain add: busy for exactly NUM_CHUNKS cycles, then the result holds.
        @(negedge clk);
        issue1(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_done1(bc);
        check("t1_busy_cycles", 32'(bc), 32'(NC));
        @(negedge clk);
        check("t1_sum_held", 32'(sum), 32'h2345);
        check("t1_done_pulse", 32'(done), 32'(0));

        // Carry ripples through every chunk.
        issue1(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done1(bc);
        @(negedge clk);
        issue1(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_done1(bc);

        // Subtract with and without borrow, back to back. The carry_in value is ignored.
        @(negedge clk);
        issue1(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_done1(bc);
        issue1(16'h0007, 16'h0005, 1'b1, 1'b1);
        wait_done1(bc);

        // Start is held high with changing operands while busy; those requests are ignored.
        // The next start is then issued during the done cycle.
        @(negedge clk);
        a = 16'h1234; b = 16'h0F0F; carry_in = 1'b1; sub = 1'b0; start = 1'b1;
        q1.push_back(model(NB, 32'h1234, 32'h0F0F, 1'b1, 1'b0, cyc, NC));
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done1(bc);
        issue1(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_done1(bc);

        // Reset during the 2nd ADD cycle abandons the operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_sum", 32'(sum), 32'(0));
        check("t5_overflow", 32'(overflow), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_done", 32'(done), 32'(0));
        repeat (8) @(negedge clk);
        issue1(16'hABCD, 16'h1234, 1'b0, 1'b0);
        wait_done1(bc);

        // Random operations with random gaps; a gap of 0 means back to back.
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            issue1(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_done1(bc);
        end
        @(negedge clk);

        // Exhaustive add-mode sweep of the 4-bit, 1-bit-chunk instance.
        for (int i = 0; i < 512; i++) begin
            issue2(i[3:0], i[7:4], i[8]);
            wait_done2();
        end

        repeat (4) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'(0));
        check("q2_drained", 32'(q2.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
